pat_frame_parser: RTL and testbench

PAT_FRAME_PARSER -- requirements
Module: pat_frame_parser

---
 rtl/pat_frame_parser.sv | 115 +++++++++++
 tb/tb_pat_frame_parser.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pat_frame_parser.sv
// Parses 6-byte position frames (HEADER XH XL YH YL CK) from the MCU UART into
// a clamped {x,y} location, with inter-byte gap timeout and link staleness tracking.
module pat_frame_parser #(
  parameter logic [7:0] HEADER    = 8'hA5,
  parameter int         X_MAX     = 1279,
  parameter int         Y_MAX     = 1023,
  parameter int         GAP_CYC   = 100000,
  parameter int         STALE_CYC = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [21:0] pat_location,
  output logic        pat_valid,
  output logic        frame_err,
  output logic        link_ok
);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int SW = $clog2(STALE_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_XH, S_XL, S_YH, S_YL, S_CK} state_t;

  state_t         state, state_nxt;
  logic [7:0]     csum;
  logic [2:0]     xh, yh;
  logic [7:0]     xl, yl;
  logic [GW-1:0]  gap_cnt;
  logic [SW-1:0]  stale_cnt;
  logic           link_up;
  logic           good, abort, timeout;
  logic [10:0]    x_full, y_full, x_clamp, y_clamp;

  assign x_full  = {xh, xl};
  assign y_full  = {yh, yl};
  assign x_clamp = (x_full > 11'(X_MAX)) ? 11'(X_MAX) : x_full;
  assign y_clamp = (y_full > 11'(Y_MAX)) ? 11'(Y_MAX) : y_full;

  // An accepted byte always beats a simultaneous gap timeout.
  always_comb begin
    state_nxt = state;
    good      = 1'b0;
    abort     = 1'b0;
    timeout   = 1'b0;
    if (rx_valid) begin
      case (state)
        S_IDLE: if (rx_data == HEADER) state_nxt = S_XH;
        S_XH:   if (|rx_data[7:3]) abort = 1'b1; else state_nxt = S_XL;
        S_XL:   state_nxt = S_YH;
        S_YH:   if (|rx_data[7:3]) abort = 1'b1; else state_nxt = S_YL;
        S_YL:   state_nxt = S_CK;
        S_CK: begin
          if (rx_data == csum) good = 1'b1; else abort = 1'b1;
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (state != S_IDLE && gap_cnt == GW'(GAP_CYC - 1)) begin
      timeout = 1'b1;
    end
    if (abort || timeout) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csum         <= 8'd0;
      xh           <= 3'd0;
      xl           <= 8'd0;
      yh           <= 3'd0;
      yl           <= 8'd0;
      gap_cnt      <= '0;
      stale_cnt    <= '0;
      link_up      <= 1'b0;
      pat_location <= 22'd0;
      pat_valid    <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      pat_valid <= good;
      frame_err <= abort | timeout;
      if (good) pat_location <= {x_clamp, y_clamp};

      if (rx_valid) begin
        case (state)
          S_IDLE:  csum <= 8'd0;
          S_XH:    begin xh <= rx_data[2:0]; csum <= csum + rx_data; end
          S_XL:    begin xl <= rx_data;      csum <= csum + rx_data; end
          S_YH:    begin yh <= rx_data[2:0]; csum <= csum + rx_data; end
          S_YL:    begin yl <= rx_data;      csum <= csum + rx_data; end
          default: ;
        endcase
      end

      if (rx_valid || state == S_IDLE || timeout) gap_cnt <= '0;
      else                                        gap_cnt <= gap_cnt + 1'b1;

      // Counter is zero in the pat_valid cycle, so link_ok falls STALE_CYC cycles later.
      if (good)                              stale_cnt <= '0;
      else if (stale_cnt != SW'(STALE_CYC))  stale_cnt <= stale_cnt + 1'b1;

      if (good)                                  link_up <= 1'b1;
      else if (stale_cnt == SW'(STALE_CYC))      link_up <= 1'b0;
    end
  end

  assign link_ok = link_up && (stale_cnt != SW'(STALE_CYC));

endmodule

// File: tb/tb_pat_frame_parser.sv
// Directed-vector bench for pat_frame_parser with short gap/stale timeouts.
module tb_pat_frame_parser;
  localparam int GAP   = 20;
  localparam int STALE = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [21:0] pat_location;
  logic        pat_valid, frame_err, link_ok;

  int n_vec = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int pv_cnt = 0;

  pat_frame_parser #(
    .HEADER(8'hA5), .X_MAX(1279), .Y_MAX(1023), .GAP_CYC(GAP), .STALE_CYC(STALE)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .pat_location(pat_location), .pat_valid(pat_valid),
    .frame_err(frame_err), .link_ok(link_ok)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err) fe_cnt++;
    if (pat_valid) pv_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] xh, xl, yh, yl, ck);
    put(8'hA5); put(xh); put(xl); put(yh); put(yl); put(ck);
    idle();
  endtask

  function automatic logic [21:0] loc(input int x, input int y);
    return {11'(x), 11'(y)};
  endfunction

  int fe0, pv0;

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_loc", 32'(pat_location), 32'd0);
    chk("rst_pv", 32'(pat_valid), 32'd0);
    chk("rst_fe", 32'(frame_err), 32'd0);
    chk("rst_link", 32'(link_ok), 32'd0);
    rst = 1'b0;

    // good frame, y=1100 clamped to 1023
    frame(8'h00, 8'hC8, 8'h04, 8'h4C, 8'h18);
    chk("f1_pv", 32'(pat_valid), 32'd1);
    chk("f1_fe", 32'(frame_err), 32'd0);
    chk("f1_loc", 32'(pat_location), 32'(loc(200, 1023)));
    chk("f1_link", 32'(link_ok), 32'd1);
    idle();
    chk("f1_pv_once", 32'(pat_valid), 32'd0);

    // bad checksum
    pv0 = pv_cnt;
    frame(8'h00, 8'hC8, 8'h04, 8'h4C, 8'h19);
    chk("ck_fe", 32'(frame_err), 32'd1);
    chk("ck_pv", 32'(pat_valid), 32'd0);
    chk("ck_loc", 32'(pat_location), 32'(loc(200, 1023)));
    idle();
    chk("ck_fe_once", 32'(frame_err), 32'd0);
    chk("ck_no_pv", 32'(pv_cnt - pv0), 32'd0);

    // junk in IDLE is silent
    fe0 = fe_cnt;
    put(8'h3C); put(8'h7F);
    frame(8'h01, 8'h00, 8'h00, 8'h64, 8'h65);
    chk("junk_pv", 32'(pat_valid), 32'd1);
    chk("junk_loc", 32'(pat_location), 32'(loc(256, 100)));
    chk("junk_no_fe", 32'(fe_cnt - fe0), 32'd0);

    // gap timeout mid-frame
    fe0 = fe_cnt;
    put(8'hA5); put(8'h00); put(8'hC8);
    repeat (GAP + 10) idle();
    chk("gap_fe", 32'(fe_cnt - fe0), 32'd1);
    chk("gap_loc", 32'(pat_location), 32'(loc(256, 100)));
    frame(8'h00, 8'h0A, 8'h00, 8'h14, 8'h1E);
    chk("gap_next_loc", 32'(pat_location), 32'(loc(10, 20)));
    chk("gap_next_pv", 32'(pat_valid), 32'd1);

    // reserved bit in XH aborts on that byte
    put(8'hA5); put(8'h08);
    idle();
    chk("rsv_fe", 32'(frame_err), 32'd1);
    frame(8'h00, 8'h05, 8'h00, 8'h06, 8'h0B);
    chk("rsv_next_loc", 32'(pat_location), 32'(loc(5, 6)));

    // reset mid-frame
    fe0 = fe_cnt;
    put(8'hA5); put(8'h00);
    @(negedge clk); rx_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mrst_loc", 32'(pat_location), 32'd0);
    chk("mrst_pv", 32'(pat_valid), 32'd0);
    chk("mrst_link", 32'(link_ok), 32'd0);
    idle();
    chk("mrst_no_fe", 32'(fe_cnt - fe0), 32'd0);
    frame(8'h00, 8'h07, 8'h00, 8'h03, 8'h0A);
    chk("mrst_next_loc", 32'(pat_location), 32'(loc(7, 3)));
    chk("mrst_next_link", 32'(link_ok), 32'd1);

    // link staleness: pat_valid cycle counts as 0
    repeat (STALE - 1) idle();
    chk("stale_before", 32'(link_ok), 32'd1);
    idle();
    chk("stale_at", 32'(link_ok), 32'd0);
    repeat (5) idle();
    chk("stale_hold", 32'(link_ok), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
